// File: rtl/mux2_rr_pkg.sv
// rtl/mux2_rr_pkg.sv - shared types and constants for the round-robin 2:1 mux arbiter
// Contents: output register state type, channel index constants, last_grant reset value.
package mux2_rr_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Reset as if ch1 won last, so ch0 wins the first contention.
    localparam logic LAST_GRANT_RST = CH1;

endpackage

// File: rtl/mux2_rr_arb_if.sv
// rtl/mux2_rr_arb_if.sv - two-source request side and registered output side of the arbiter
// Signals: in_data (2*W, ch0 low half), in_valid[1:0], in_ready[1:0],
//          out_data (W), out_sel, out_valid, out_ready.
// Modports: slave = arbiter view, master = surrounding sources/sink view.
interface mux2_rr_arb_if #(
    parameter int W = 8
);
    logic [2*W-1:0] in_data;
    logic [1:0]     in_valid;
    logic [1:0]     in_ready;
    logic [W-1:0]   out_data;
    logic           out_sel;
    logic           out_valid;
    logic           out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux2.sv
// rtl/mux2.sv - 2:1 data mux
// Ports: a (selected when s=0), b (selected when s=1), s, y.
module mux2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - combinational two-way round-robin grant
// Ports: in_valid[1:0], last_grant, can_load in; grant_valid, grant_idx out.
module rr_grant2 (
    input  logic [1:0] in_valid,
    input  logic       last_grant,
    input  logic       can_load,
    output logic       grant_valid,
    output logic       grant_idx
);
    import mux2_rr_pkg::*;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = CH0;
        // Gating on can_load keeps in_valid from reaching in_ready while blocked.
        if (can_load) begin
            case (in_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_idx   = CH0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_idx   = CH1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_idx   = ~last_grant;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_idx   = CH0;
                end
            endcase
        end
    end
endmodule

// File: rtl/mux2_rr_arb.sv
// rtl/mux2_rr_arb.sv - round-robin arbiter driving a registered 2:1 mux with valid/ready output
// Ports: clk, rst_n (async active-low), bus (mux2_rr_arb_if.slave),
//        grant_cnt0/grant_cnt1 saturating grant counters (only with MUX2_RR_STATS_EN).
// Option: MUX2_RR_STATS_EN adds the CNT_W parameter and the grant counters.
module mux2_rr_arb #(
    parameter int W = 8
`ifdef MUX2_RR_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_rr_arb_if.slave      bus
`ifdef MUX2_RR_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);
    import mux2_rr_pkg::*;

    state_t         state_q, state_d;
    logic [W-1:0]   data_q;
    logic           sel_q;
    logic           last_grant_q;
    logic           can_load;
    logic           grant_valid;
    logic           grant_idx;
    logic [W-1:0]   mux_y;

    // rst_n is folded in so in_ready stays 00 while reset is held,
    // even though the register reads EMPTY then.
    assign can_load = rst_n && ((state_q == EMPTY) || bus.out_ready);

    rr_grant2 u_grant (
        .in_valid    (bus.in_valid),
        .last_grant  (last_grant_q),
        .can_load    (can_load),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    mux2 #(.W(W)) u_mux (
        .a (bus.in_data[W-1:0]),
        .b (bus.in_data[2*W-1:W]),
        .s (grant_idx),
        .y (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            sel_q        <= CH0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            state_q <= state_d;
            if (grant_valid) begin
                data_q       <= mux_y;
                sel_q        <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 2'b00;
        if (grant_valid) begin
            // A grant always refills; a simultaneous pop leaves the register FULL.
            state_d      = FULL;
            bus.in_ready = grant_idx ? 2'b10 : 2'b01;
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

`ifdef MUX2_RR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant_valid) begin
            if ((grant_idx == CH0) && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
            if ((grant_idx == CH1) && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end
        end
    end
`endif

endmodule
